// File: rtl/control_unit.sv
// control_unit: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV64-subset datapath.
// Optional retired-instruction counter is built only when INSTR_COUNT_EN is defined.
module control_unit #(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             mem_ready,
    output logic             ir_load,
    output logic             load_en,
    output logic             store_en,
    output logic [1:0]       op_ula,
    output logic             operation_type,
    output logic             ula_entry,
    output logic             pc_en,
    output logic             busy,
    output logic             illegal,
    output logic             mem_err,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_LOAD, C_STORE, C_ADD, C_SUB, C_ADDI, C_SUBI, C_NONE
    } iclass_t;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t     state_q, state_d;
    iclass_t    cls_q, cls_d, dec_cls;
    logic [7:0] wait_q, wait_d;
    logic       illegal_q, illegal_d;
    logic       mem_err_q, mem_err_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cls_q     <= C_NONE;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            mem_err_q <= mem_err_d;
        end
    end

    always_comb begin
        dec_cls = C_NONE;
        case (opcode)
            7'b0000011: if (funct3 == 3'b011) dec_cls = C_LOAD;
            7'b0100011: if (funct3 == 3'b011) dec_cls = C_STORE;
            7'b0110011: begin
                if (funct3 == 3'b000 && funct7 == 7'b0000000) dec_cls = C_ADD;
                else if (funct3 == 3'b000 && funct7 == 7'b0100000) dec_cls = C_SUB;
            end
            7'b0010011: if (funct3 == 3'b000) dec_cls = C_ADDI;
            7'b0001011: if (funct3 == 3'b000) dec_cls = C_SUBI;
            default:    dec_cls = C_NONE;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        cls_d          = cls_q;
        wait_d         = wait_q;
        illegal_d      = illegal_q;
        mem_err_d      = mem_err_q;
        ir_load        = 1'b0;
        load_en        = 1'b0;
        store_en       = 1'b0;
        pc_en          = 1'b0;
        op_ula         = 2'b00;
        operation_type = 1'b0;
        ula_entry      = 1'b0;

        // ALU controls follow the registered class for the life of the instruction
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            case (cls_q)
                C_LOAD, C_STORE: op_ula = 2'b01;
                C_ADD:   begin op_ula = 2'b01; ula_entry = 1'b1; operation_type = 1'b1; end
                C_SUB:   begin op_ula = 2'b00; ula_entry = 1'b1; operation_type = 1'b1; end
                C_ADDI:  begin op_ula = 2'b01; operation_type = 1'b1; end
                C_SUBI:  begin op_ula = 2'b00; operation_type = 1'b1; end
                default: op_ula = 2'b00;
            endcase
        end

        case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH: begin
                ir_load = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (dec_cls == C_NONE) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    cls_d   = dec_cls;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                wait_d  = '0;
                state_d = (cls_q == C_LOAD || cls_q == C_STORE) ? S_MEM : S_WB;
            end
            S_MEM: begin
                store_en = (cls_q == C_STORE);
                if (mem_ready) begin
                    if (cls_q == C_STORE) begin
                        pc_en   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    mem_err_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                load_en = 1'b1;
                pc_en   = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
    assign illegal = illegal_q;
    assign mem_err = mem_err_q;

`ifdef INSTR_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else if (pc_en) cnt_q <= cnt_q + CNT_W'(1);
    end

    assign instr_count = cnt_q;
`else
    assign instr_count = '0;
`endif

endmodule
